// File: rtl/shift_rotate_unit_if.sv
// Handshake/data bundle for shift_rotate_unit.
//   master : issues operations (in_*) and accepts results (out_ready)
//   slave  : the execution unit; accepts in_*, produces out_* and in_ready
// Signals: in_valid/in_ready, in_op[2:0], in_num[WIDTH], in_amt[AMT_W],
//          in_cin, in_tag[TAG_W]; out_valid/out_ready, out_res[WIDTH],
//          out_cout, out_n, out_z, out_err, out_tag[TAG_W].
interface shift_rotate_unit_if #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 8,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_num;
   logic [AMT_W-1:0] in_amt;
   logic             in_cin;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic             out_cout;
   logic             out_n;
   logic             out_z;
   logic             out_err;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_op, in_num, in_amt, in_cin, in_tag, out_ready,
      input  in_ready, out_valid, out_res, out_cout, out_n, out_z, out_err, out_tag
   );

   modport slave (
      input  in_valid, in_op, in_num, in_amt, in_cin, in_tag, out_ready,
      output in_ready, out_valid, out_res, out_cout, out_n, out_z, out_err, out_tag
   );
endinterface

// File: rtl/shift_rotate_unit.sv
// Two-stage pipelined shift/rotate unit: LSL, LSR, ASR, ROR, RRX with
// shifter carry-out and N/Z flags, valid/ready on both sides.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - synchronous active-low reset
//   bus    - shift_rotate_unit_if.slave (operation in, result out)
//
// Every op is reduced to: res = (rotr(s, k) & mask) | (fill & ~mask).
// Stage A decodes op/amount into k/mask/fill/carry-select and applies the
// low rotator levels; stage B applies the high levels, picks the carry and
// forms N/Z. The carry always falls on bit 0 or bit WIDTH-1 of the rotated
// value (or is cin / 0), so only a 2-bit select travels down the pipe.
module shift_rotate_unit #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 8,
   parameter int TAG_W = 4
) (
   input logic                clk,
   input logic                rst_n,
   shift_rotate_unit_if.slave bus
);
   localparam int LG     = $clog2(WIDTH);
   localparam int LO_LVL = LG / 2;
   localparam logic [WIDTH-1:0] ONES = '1;

   typedef enum logic [1:0] {C_CIN, C_ZERO, C_MSB, C_LSB} csel_e;

   // Right-rotate by the bits of k that lie in levels [lo, hi).
   function automatic logic [WIDTH-1:0] rotr_lvls(input logic [WIDTH-1:0] v,
                                                  input logic [LG-1:0] k,
                                                  input int lo, input int hi);
      logic [WIDTH-1:0] r;
      r = v;
      for (int l = 0; l < LG; l++)
         if (l >= lo && l < hi && k[l])
            r = (r >> (1 << l)) | (r << (WIDTH - (1 << l)));
      return r;
   endfunction

   // ---------------- handshake ----------------
   logic a_vld_q, a_vld_d, b_vld_q, b_vld_d;
   logic b_free, accept, advance;

   assign b_free       = !b_vld_q | bus.out_ready;
   assign bus.in_ready = !a_vld_q | b_free;
   assign accept       = bus.in_valid & bus.in_ready;
   assign advance      = a_vld_q & b_free;

   always_comb begin
      a_vld_d = accept | (a_vld_q & !advance);
      b_vld_d = advance | (b_vld_q & !bus.out_ready);
   end

   // ---------------- stage A decode ----------------
   logic [LG-1:0]    a_lo;
   logic             amt_zero, amt_lt, amt_eq;
   logic [LG-1:0]    dec_k;
   logic [WIDTH-1:0] dec_mask, dec_fill;
   csel_e            dec_csel;
   logic             dec_err;

   assign a_lo     = bus.in_amt[LG-1:0];
   assign amt_zero = (bus.in_amt == '0);
   assign amt_lt   = (bus.in_amt < AMT_W'(WIDTH));
   assign amt_eq   = (bus.in_amt == AMT_W'(WIDTH));

   always_comb begin
      // Defaults give pass-through with cout = cin (amount 0, illegal op).
      dec_k    = '0;
      dec_mask = ONES;
      dec_fill = '0;
      dec_csel = C_CIN;
      dec_err  = 1'b0;
      unique case (bus.in_op)
         3'b000: if (!amt_zero) begin          // LSL == rotr by W-a, keep upper bits
            dec_mask = '0;
            dec_csel = (amt_lt || amt_eq) ? C_LSB : C_ZERO;
            if (amt_lt) begin
               dec_k    = LG'(0) - a_lo;
               dec_mask = ONES << a_lo;
            end
         end
         3'b001: if (!amt_zero) begin          // LSR
            dec_mask = '0;
            dec_csel = (amt_lt || amt_eq) ? C_MSB : C_ZERO;
            if (amt_lt) begin
               dec_k    = a_lo;
               dec_mask = ONES >> a_lo;
            end
         end
         3'b010: if (!amt_zero) begin          // ASR: sign fills vacated bits
            dec_mask = '0;
            dec_fill = {WIDTH{bus.in_num[WIDTH-1]}};
            dec_csel = C_MSB;
            if (amt_lt) begin
               dec_k    = a_lo;
               dec_mask = ONES >> a_lo;
            end
         end
         3'b011: if (!amt_zero) begin          // ROR: amount mod W
            dec_k    = a_lo;
            dec_csel = C_MSB;
         end
         3'b100: begin                         // RRX: rotr 1, cin into MSB
            dec_k             = LG'(1);
            dec_mask          = ONES >> 1;
            dec_fill[WIDTH-1] = bus.in_cin;
            dec_csel          = C_MSB;
         end
         default: dec_err = 1'b1;
      endcase
   end

   // ---------------- stage A / B registers ----------------
   logic [WIDTH-1:0] a_rot_q, a_mask_q, a_fill_q;
   logic [LG-1:0]    a_k_q;
   csel_e            a_csel_q;
   logic             a_cin_q, a_err_q;
   logic [TAG_W-1:0] a_tag_q;

   logic [WIDTH-1:0] b_rot, b_res;
   logic             b_cout;

   always_comb begin
      b_rot = rotr_lvls(a_rot_q, a_k_q, LO_LVL, LG);
      b_res = (b_rot & a_mask_q) | (a_fill_q & ~a_mask_q);
      unique case (a_csel_q)
         C_MSB:   b_cout = b_rot[WIDTH-1];
         C_LSB:   b_cout = b_rot[0];
         C_ZERO:  b_cout = 1'b0;
         default: b_cout = a_cin_q;
      endcase
   end

   logic [WIDTH-1:0] out_res_q;
   logic             out_cout_q, out_n_q, out_z_q, out_err_q;
   logic [TAG_W-1:0] out_tag_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_vld_q    <= 1'b0;
         b_vld_q    <= 1'b0;
         out_res_q  <= '0;
         out_cout_q <= 1'b0;
         out_n_q    <= 1'b0;
         out_z_q    <= 1'b0;
         out_err_q  <= 1'b0;
         out_tag_q  <= '0;
      end else begin
         a_vld_q <= a_vld_d;
         b_vld_q <= b_vld_d;
         if (accept) begin
            a_rot_q  <= rotr_lvls(bus.in_num, dec_k, 0, LO_LVL);
            a_k_q    <= dec_k;
            a_mask_q <= dec_mask;
            a_fill_q <= dec_fill;
            a_csel_q <= dec_csel;
            a_cin_q  <= bus.in_cin;
            a_err_q  <= dec_err;
            a_tag_q  <= bus.in_tag;
         end
         if (advance) begin
            out_res_q  <= b_res;
            out_cout_q <= b_cout;
            out_n_q    <= b_res[WIDTH-1];
            out_z_q    <= (b_res == '0);
            out_err_q  <= a_err_q;
            out_tag_q  <= a_tag_q;
         end
      end
   end

   assign bus.out_valid = b_vld_q;
   assign bus.out_res   = out_res_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.out_n     = out_n_q;
   assign bus.out_z     = out_z_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_tag   = out_tag_q;
endmodule
